alu_sequencer: RTL and testbench

Multi-cycle controller that sequences a single shared 4-bit ripple-carry adder and the ALU logic functions to execute 8-bit commands: 8-bit add (two nibble passes with carry chaining), 4x4 unsigned shift-add multiply, and the single-pass OR/AND/concat operations. It sits between a command source and a result consumer, both using valid/ready handshakes. It replaces the combinational-only ALU path wherever results wider than one adder pass are needed.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/adder4.sv | 21 ++
 rtl/alu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the multi-cycle ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned OPND_W    = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned MUL_STEPS = 4;
  localparam int unsigned STEP_W    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD8 = 3'd0,
    OP_OR   = 3'd1,
    OP_AND  = 3'd2,
    OP_CAT  = 3'd3,
    OP_MUL4 = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADD_LO = 3'd1,
    S_ADD_HI = 3'd2,
    S_EXEC   = 3'd3,
    S_MUL    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Command captured at accept; op kept raw so illegal codes survive to EXEC.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// Command/result valid-ready bus between a command source and the sequencer.
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [OPND_W-1:0] cmd_a;
  logic [OPND_W-1:0] cmd_b;
  logic              res_valid;
  logic              res_ready;
  logic [OPND_W-1:0] res_data;
  logic              res_carry;
  logic              res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_err
  );
endinterface

// File: rtl/adder4.sv
// 4-bit ripple-carry adder built from full-adder cells; the sequencer's only adder.
module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: ADD8 in two nibble passes, 4x4 shift-add MUL,
// single-pass logic ops, all through one shared adder4.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic                carry_q, carry_d;
  logic [OPND_W-1:0]   prod_q, prod_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [OPND_W-1:0]   res_data_q, res_data_d;
  logic                res_carry_q, res_carry_d;
  logic                res_err_q, res_err_d;
  logic                res_valid_q, res_valid_d;
  logic                cmd_ready_q, cmd_ready_d;

  logic                accept_c;
  logic [NIB_W-1:0]    add_a_c, add_b_c, add_sum_c;
  logic                add_cin_c, add_cout_c;
  logic [OPND_W-1:0]   mul_next_c;

  assign accept_c = bus.cmd_valid && (state_q == S_IDLE);

  // Shared adder operand select: nibble passes for ADD8, partial sum for MUL.
  always_comb begin
    add_a_c   = '0;
    add_b_c   = '0;
    add_cin_c = 1'b0;
    case (state_q)
      S_ADD_LO: begin
        add_a_c = cmd_q.a[NIB_W-1:0];
        add_b_c = cmd_q.b[NIB_W-1:0];
      end
      S_ADD_HI: begin
        add_a_c   = cmd_q.a[OPND_W-1:NIB_W];
        add_b_c   = cmd_q.b[OPND_W-1:NIB_W];
        add_cin_c = carry_q;
      end
      S_MUL: begin
        add_a_c = prod_q[OPND_W-1:NIB_W];
        add_b_c = prod_q[0] ? cmd_q.a[NIB_W-1:0] : '0;
      end
      default: ;
    endcase
  end

  adder4 u_adder (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (add_cin_c),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  assign mul_next_c = {add_cout_c, add_sum_c, prod_q[NIB_W-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          case (bus.cmd_op)
            OP_ADD8: state_d = S_ADD_LO;
            OP_MUL4: state_d = S_MUL;
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_ADD_LO: state_d = S_ADD_HI;
      S_ADD_HI: state_d = S_DONE;
      S_EXEC:   state_d = S_DONE;
      S_MUL:    if (step_q == LAST_STEP) state_d = S_DONE;
      S_DONE:   if (bus.res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cmd_d       = cmd_q;
    carry_d     = carry_q;
    prod_d      = prod_q;
    step_d      = step_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cmd_d  = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
          prod_d = {NIB_W'(0), bus.cmd_b[NIB_W-1:0]};
          step_d = '0;
        end
      end
      S_ADD_LO: begin
        res_data_d[NIB_W-1:0] = add_sum_c;
        carry_d               = add_cout_c;
      end
      S_ADD_HI: begin
        res_data_d[OPND_W-1:NIB_W] = add_sum_c;
        res_carry_d                = add_cout_c;
        res_valid_d                = 1'b1;
      end
      S_EXEC: begin
        res_valid_d = 1'b1;
        case (cmd_q.op)
          OP_OR:   res_data_d = OPND_W'(|{cmd_q.a[NIB_W-1:0], cmd_q.b[NIB_W-1:0]});
          OP_AND:  res_data_d = OPND_W'(&{cmd_q.a[NIB_W-1:0], cmd_q.b[NIB_W-1:0]});
          OP_CAT:  res_data_d = {cmd_q.a[NIB_W-1:0], cmd_q.b[NIB_W-1:0]};
          default: begin
            res_data_d = '0;
            res_err_d  = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        prod_d = mul_next_c;
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) begin
          res_data_d  = mul_next_c;
          res_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          res_carry_d = 1'b0;
        end
      end
      default: ;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      carry_q     <= 1'b0;
      prod_q      <= '0;
      step_q      <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      cmd_q       <= cmd_d;
      carry_q     <= carry_d;
      prod_q      <= prod_d;
      step_q      <= step_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed plan items plus random commands
// checked against an arithmetic reference model.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, carry, data} from plain arithmetic on the opcode rules.
  function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd0: begin s = 9'(a) + 9'(b); return {1'b0, s}; end
      3'd1: return {2'b00, 7'd0, (a[3:0] != 4'd0) || (b[3:0] != 4'd0)};
      3'd2: return {2'b00, 7'd0, (a[3:0] == 4'hF) && (b[3:0] == 4'hF)};
      3'd3: return {2'b00, a[3:0], b[3:0]};
      3'd4: return {2'b00, 8'(a[3:0] * b[3:0])};
      default: return {1'b1, 1'b0, 8'h00};
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
    if (op == 3'd0) return 2;
    if (op == 3'd4) return 4;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, check latency and result, optionally stall the consumer.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [9:0] exp;
    int         lat;
    exp = model(op, a, b);
    bus.res_ready = (stall == 0);
    @(negedge clk);
    chk("cmd_ready_idle", 8'(bus.cmd_ready), 8'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'($urandom);
    bus.cmd_b     = 8'($urandom);
    chk("cmd_ready_busy", 8'(bus.cmd_ready), 8'd0);
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 8'(lat), 8'(latency(op)));
    chk("res_data", bus.res_data, exp[7:0]);
    chk("res_carry", 8'(bus.res_carry), 8'(exp[8]));
    chk("res_err", 8'(bus.res_err), 8'(exp[9]));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", 8'(bus.res_valid), 8'd1);
      chk("stall_data", bus.res_data, exp[7:0]);
      chk("stall_ready", 8'(bus.cmd_ready), 8'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed_valid", 8'(bus.res_valid), 8'd0);
    chk("consumed_ready", 8'(bus.cmd_ready), 8'd1);
    chk("consumed_err", 8'(bus.res_err), 8'd0);
    chk("consumed_carry", 8'(bus.res_carry), 8'd0);
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h00;
    bus.cmd_b     = 8'h00;
    bus.res_ready = 1'b1;
    #1;
    chk("reset_valid", 8'(bus.res_valid), 8'd0);
    chk("reset_data", bus.res_data, 8'h00);
    chk("reset_carry", 8'(bus.res_carry), 8'd0);
    chk("reset_err", 8'(bus.res_err), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_cmd_ready", 8'(bus.cmd_ready), 8'd1);

    // Directed plan items
    send(3'd0, 8'hF7, 8'h1A, 0);
    send(3'd4, 8'h0F, 8'h0D, 0);
    send(3'd4, 8'h00, 8'h0F, 0);
    send(3'd3, 8'h0A, 8'h05, 0);
    send(3'd1, 8'h00, 8'h00, 0);
    send(3'd2, 8'h0F, 8'h0F, 0);
    send(3'd2, 8'h0F, 8'h0E, 0);
    send(3'd6, 8'h5A, 8'hA5, 0);
    send(3'd1, 8'h03, 8'h00, 0);

    // Backpressure with a new command held on cmd_valid the whole time
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = 8'h9C;
    bus.cmd_b     = 8'h7B;
    @(posedge clk); #1;
    bus.cmd_op = 3'd3;
    bus.cmd_a  = 8'h03;
    bus.cmd_b  = 8'h0C;
    lat = 0;
    while (!bus.res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 8'(lat), 8'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 8'(bus.res_valid), 8'd1);
      chk("bp_data", bus.res_data, 8'h17);
      chk("bp_carry", 8'(bus.res_carry), 8'd1);
      chk("bp_cmd_ready", 8'(bus.cmd_ready), 8'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_consume_valid", 8'(bus.res_valid), 8'd0);
    chk("bp_consume_ready", 8'(bus.cmd_ready), 8'd1);
    @(posedge clk); #1;
    chk("bp_held_accept", 8'(bus.cmd_ready), 8'd0);
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_held_valid", 8'(bus.res_valid), 8'd1);
    chk("bp_held_data", bus.res_data, 8'h3C);
    @(posedge clk); #1;
    chk("bp_held_done", 8'(bus.res_valid), 8'd0);

    // Reset during MUL step 2
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_a     = 8'h0B;
    bus.cmd_b     = 8'h07;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst_mul_valid", 8'(bus.res_valid), 8'd0);
    chk("rst_mul_data", bus.res_data, 8'h00);
    chk("rst_mul_carry", 8'(bus.res_carry), 8'd0);
    chk("rst_mul_err", 8'(bus.res_err), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mul_ready", 8'(bus.cmd_ready), 8'd1);
    chk("rst_mul_idle", 8'(bus.res_valid), 8'd0);
    send(3'd0, 8'h3C, 8'hD5, 0);

    // Random commands, all opcodes, random consumer stalls
    for (int n = 0; n < 60; n++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
